// File: rtl/vector_store_unit.sv
// vector_store_unit: takes one LANES x LANE_W vector from the ALU and writes
// it to the data-memory port one word per handshake. Lanes whose mask bit is
// clear are skipped, each costing one cycle. busy stalls the pipeline while a
// vector drains, and done pulses for one cycle when the store completes.
module vector_store_unit #(
    parameter int LANES  = 8,
    parameter int LANE_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       baseAddr,
    input  logic [LANES*LANE_W-1:0] storeData,
    input  logic [LANES-1:0]        laneMask,
    input  logic                    memReady,
    output logic                    memWe,
    output logic [ADDR_W-1:0]       memAddr,
    output logic [LANE_W-1:0]       memWriteData,
    output logic                    busy,
    output logic                    done
);
    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]                    state_q, state_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic [LANES-1:0][LANE_W-1:0]  data_q, data_d;
    logic [LANES-1:0]              mask_q, mask_d;
    logic [ADDR_W-1:0]             base_q, base_d;
    logic                          lane_wr;

    // Next-state: latch the vector in IDLE, then step one lane per accepted
    // write or per skipped lane; the final lane hands over to DONE.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        mask_d  = mask_q;
        base_d  = base_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    data_d  = storeData;
                    mask_d  = laneMask;
                    base_d  = baseAddr;
                    idx_d   = '0;
                    state_d = (laneMask == '0) ? S_DONE : S_WRITE;
                end
            end
            S_WRITE: begin
                // A masked-off lane never waits on memReady.
                if (!mask_q[idx_q] || memReady) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset abandons any store in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            mask_q  <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
            base_q  <= base_d;
        end
    end

    // Outputs decode registered state only, so they hold steady while the
    // memory withholds memReady. Address arithmetic wraps modulo 2^ADDR_W.
    always_comb begin
        lane_wr      = (state_q == S_WRITE) && mask_q[idx_q];
        memWe        = lane_wr;
        memAddr      = lane_wr ? (base_q + (ADDR_W'(idx_q) << 2)) : '0;
        memWriteData = lane_wr ? data_q[idx_q] : '0;
        busy         = (state_q != S_IDLE);
        done         = (state_q == S_DONE);
    end
endmodule
